// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file defaults and address qualification
// Purpose : default geometry for regfile_sb and the addr_ok() helper that decides
//           whether an address names a real, writable register. The control FSM
//           calls the same helper in its stall logic, so the rule lives in one place.
// Ports   : none (package)
package regfile_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NREGS_DEF  = 8;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_IDX   = 0;

   // True when addr is inside the implemented range and is not the hardwired zero register.
   function automatic logic addr_ok(input logic [31:0] addr,
                                    input int unsigned nregs,
                                    input logic        zero_reg);
      return (addr < nregs) && !(zero_reg && (addr == 32'(ZERO_IDX)));
   endfunction

endpackage

// File: rtl/regfile_sb_read_port.sv
// rtl/regfile_sb_read_port.sv - one read port: range check, write bypass, busy qualification
// Purpose : turns the raw storage/busy lookup for one read address into the
//           architecturally visible read data and busy flag.
// Ports   : raddr_i              read address
//           rd_data_i/rd_busy_i  raw storage word and busy bit at raddr_i
//           wrN_ok_i             write port N enable, already range/zero qualified
//           waddrN_i/wdataN_i    write port N address and data
//           rdata_o              read data (0 for illegal addresses)
//           busy_o               pending-write flag, cleared when the clearing write is bypassed
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic              rd_busy_i,
   input  logic              wr0_ok_i,
   input  logic [ADDR_W-1:0] waddr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic              wr1_ok_i,
   input  logic [ADDR_W-1:0] waddr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o
);

   localparam logic        ZR = (ZERO_REG != 0);
   localparam logic        BY = (BYPASS != 0);
   localparam int unsigned NR = NREGS;

   logic rd_ok;
   logic hit0;
   logic hit1;

   assign rd_ok = addr_ok(32'(raddr_i), NR, ZR);

   // Write enables arrive already qualified, so a hit can never land on the zero register.
   assign hit0 = BY & wr0_ok_i & (waddr0_i == raddr_i);
   assign hit1 = BY & wr1_ok_i & (waddr1_i == raddr_i);

   always_comb begin
      rdata_o = '0;
      if (rd_ok) begin
         if (hit1) begin
            rdata_o = wdata1_i;
         end else if (hit0) begin
            rdata_o = wdata0_i;
         end else begin
            rdata_o = rd_data_i;
         end
      end
   end

   // A write that is visible through the bypass already satisfies the reader, so no stall.
   assign busy_o = rd_ok & rd_busy_i & ~(hit0 | hit1);

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R/2W register file with per-register busy scoreboard
// Purpose : architectural registers between decode and the ALU/memory writeback
//           paths, with write-to-read bypass and pending-write tracking for RAW/WAW stalls.
// Ports   : ph1, reset             clock, synchronous active-high reset
//           we0/waddr0/wdata0      write port 0 (ALU writeback)
//           we1/waddr1/wdata1      write port 1 (memory writeback, wins on collision)
//           raddr_a/b, rdata_a/b   combinational read ports
//           rsv_en/rsv_addr        mark a register busy for a pending multicycle write
//           busy_a/b, hazard       scoreboard status for the control FSM
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              ph1,
   input  logic              reset,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              busy_a,
   output logic              busy_b,
   output logic              hazard
);

   // Storage spans the full address space so every index is in range; entries at
   // or above NREGS are never written and stay at their reset value.
   localparam int          DEPTH = 1 << ADDR_W;
   localparam logic        ZR    = (ZERO_REG != 0);
   localparam int unsigned NR    = NREGS;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic wr0_ok;
   logic wr1_ok;
   logic rsv_ok;

   assign wr0_ok = we0    & addr_ok(32'(waddr0), NR, ZR);
   assign wr1_ok = we1    & addr_ok(32'(waddr1), NR, ZR);
   assign rsv_ok = rsv_en & addr_ok(32'(rsv_addr), NR, ZR);

   // Port 1 is applied after port 0 so it wins a same-address collision; the
   // reservation is applied last so a new reservation survives a same-cycle write.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (wr0_ok) begin
         mem_d[waddr0]  = wdata0;
         busy_d[waddr0] = 1'b0;
      end
      if (wr1_ok) begin
         mem_d[waddr1]  = wdata1;
         busy_d[waddr1] = 1'b0;
      end
      if (rsv_ok) begin
         busy_d[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   rf_read_port #(
      .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_port_a (
      .raddr_i  (raddr_a),
      .rd_data_i(mem_q[raddr_a]),
      .rd_busy_i(busy_q[raddr_a]),
      .wr0_ok_i (wr0_ok),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .wr1_ok_i (wr1_ok),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .rdata_o  (rdata_a),
      .busy_o   (busy_a)
   );

   rf_read_port #(
      .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_port_b (
      .raddr_i  (raddr_b),
      .rd_data_i(mem_q[raddr_b]),
      .rd_busy_i(busy_q[raddr_b]),
      .wr0_ok_i (wr0_ok),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .wr1_ok_i (wr1_ok),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .rdata_o  (rdata_b),
      .busy_o   (busy_b)
   );

   // WAW: reserving a register that is still pending also stalls.
   assign hazard = busy_a | busy_b | (rsv_ok & busy_q[rsv_addr]);

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (three parameter sets)
module tb_regfile_sb;

   logic ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   logic        reset, we0, we1, rsv_en;
   logic [4:0]  waddr0, waddr1, raddr_a, raddr_b, rsv_addr;
   logic [15:0] wdata0, wdata1;

   logic [7:0]  rda0, rdb0, rda1, rdb1;
   logic [15:0] rda2, rdb2;
   logic [2:0]  ba, bb, hz;

   // inst 0: defaults (bypass); inst 1: BYPASS=0; inst 2: NREGS=6, ADDR_W=3, DATA_W=16
   regfile_sb u_dut0 (
      .ph1(ph1), .reset(reset),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0[7:0]),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1[7:0]),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda0), .rdata_b(rdb0),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_a(ba[0]), .busy_b(bb[0]), .hazard(hz[0])
   );

   regfile_sb #(.BYPASS(0)) u_dut1 (
      .ph1(ph1), .reset(reset),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0[7:0]),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1[7:0]),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda1), .rdata_b(rdb1),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_a(ba[1]), .busy_b(bb[1]), .hazard(hz[1])
   );

   regfile_sb #(.DATA_W(16), .NREGS(6), .ADDR_W(3)) u_dut2 (
      .ph1(ph1), .reset(reset),
      .we0(we0), .waddr0(waddr0[2:0]), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1[2:0]), .wdata1(wdata1),
      .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .rdata_a(rda2), .rdata_b(rdb2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]),
      .busy_a(ba[2]), .busy_b(bb[2]), .hazard(hz[2])
   );

   // Reference model: architectural register contents and pending flags per instance.
   int unsigned cfg_n  [3] = '{8, 8, 6};
   int unsigned cfg_aw [3] = '{5, 5, 3};
   logic [15:0] cfg_dm [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
   bit          cfg_by [3] = '{1'b1, 1'b0, 1'b1};
   logic [15:0] m_reg  [3][32];
   bit          m_busy [3][32];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned loc(input int i, input logic [4:0] a);
      return 32'(a) % (32'd1 << cfg_aw[i]);
   endfunction

   function automatic bit legal(input int i, input int unsigned r);
      return (r < cfg_n[i]) && (r != 0);
   endfunction

   task automatic exp_read(input int i, input logic [4:0] addr,
                           output logic [15:0] d, output bit b);
      int unsigned r;
      bit hit;
      r   = loc(i, addr);
      hit = 1'b0;
      d   = 16'h0;
      b   = 1'b0;
      if (legal(i, r)) begin
         d = m_reg[i][r];
         if (cfg_by[i] && we0 && legal(i, loc(i, waddr0)) && loc(i, waddr0) == r) begin
            d = wdata0; hit = 1'b1;
         end
         if (cfg_by[i] && we1 && legal(i, loc(i, waddr1)) && loc(i, waddr1) == r) begin
            d = wdata1; hit = 1'b1;
         end
         d = d & cfg_dm[i];
         b = m_busy[i][r] && !hit;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int unsigned w0, w1, rs;
         w0 = loc(i, waddr0);
         w1 = loc(i, waddr1);
         rs = loc(i, rsv_addr);
         if (reset) begin
            for (int r = 0; r < 32; r++) begin
               m_reg[i][r]  = 16'h0;
               m_busy[i][r] = 1'b0;
            end
         end else begin
            if (we0 && legal(i, w0)) begin m_reg[i][w0] = wdata0 & cfg_dm[i]; m_busy[i][w0] = 1'b0; end
            if (we1 && legal(i, w1)) begin m_reg[i][w1] = wdata1 & cfg_dm[i]; m_busy[i][w1] = 1'b0; end
            if (rsv_en && legal(i, rs)) m_busy[i][rs] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         logic [15:0] ea, eb, ga, gb;
         bit eba, ebb, ehz;
         int unsigned rs;
         exp_read(i, raddr_a, ea, eba);
         exp_read(i, raddr_b, eb, ebb);
         rs  = loc(i, rsv_addr);
         ehz = eba || ebb || (rsv_en && legal(i, rs) && m_busy[i][rs]);
         case (i)
            0:       begin ga = {8'h0, rda0}; gb = {8'h0, rdb0}; end
            1:       begin ga = {8'h0, rda1}; gb = {8'h0, rdb1}; end
            default: begin ga = rda2;         gb = rdb2;         end
         endcase
         check($sformatf("model_rdata_a[%0d]", i), 32'(ga), 32'(ea));
         check($sformatf("model_rdata_b[%0d]", i), 32'(gb), 32'(eb));
         check($sformatf("model_busy_a[%0d]", i), 32'(ba[i]), 32'(eba));
         check($sformatf("model_busy_b[%0d]", i), 32'(bb[i]), 32'(ebb));
         check($sformatf("model_hazard[%0d]", i), 32'(hz[i]), 32'(ehz));
      end
   endtask

   task automatic tick();
      @(posedge ph1);
      model_edge();
      @(negedge ph1);
   endtask

   task automatic idle();
      reset = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
      waddr0 = '0; waddr1 = '0; raddr_a = '0; raddr_b = '0; rsv_addr = '0;
      wdata0 = '0; wdata1 = '0;
   endtask

   typedef struct {
      logic        rst, w0, w1, rsv;
      logic [4:0]  a0, a1, rs, ra, rb;
      logic [15:0] d0, d1;
      logic [7:0]  ex_ra, ex_rb;
      logic        ex_ba, ex_bb, ex_hz;
   } vec_t;

   function automatic vec_t v(input int rst, input int w0, input int a0, input int d0,
                              input int w1, input int a1, input int d1,
                              input int rsv, input int rs, input int ra, input int rb,
                              input int era, input int erb, input int eba, input int ebb, input int ehz);
      vec_t x;
      x.rst = 1'(rst); x.w0 = 1'(w0); x.a0 = 5'(a0); x.d0 = 16'(d0);
      x.w1 = 1'(w1); x.a1 = 5'(a1); x.d1 = 16'(d1);
      x.rsv = 1'(rsv); x.rs = 5'(rs); x.ra = 5'(ra); x.rb = 5'(rb);
      x.ex_ra = 8'(era); x.ex_rb = 8'(erb);
      x.ex_ba = 1'(eba); x.ex_bb = 1'(ebb); x.ex_hz = 1'(ehz);
      return x;
   endfunction

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
   endfunction

   vec_t tbl [17];

   initial begin
      //             rst w0 a0 d0     w1 a1 d1     rsv rs ra rb  era    erb    ba bb hz
      tbl[0]  = v(0, 1, 3, 'hA5,  0, 0, 0,     0, 0,  3, 0, 'hA5, 'h00,  0, 0, 0);
      tbl[1]  = v(0, 1, 0, 'hFF,  0, 0, 0,     0, 0,  3, 0, 'hA5, 'h00,  0, 0, 0);
      tbl[2]  = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  0, 3, 'h00, 'hA5,  0, 0, 0);
      tbl[3]  = v(0, 1, 2, 'h11,  1, 2, 'h22,  0, 0,  2, 3, 'h22, 'hA5,  0, 0, 0);
      tbl[4]  = v(0, 1, 4, 'h33,  0, 0, 0,     0, 0,  2, 4, 'h22, 'h33,  0, 0, 0);
      tbl[5]  = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  4, 2, 'h33, 'h22,  0, 0, 0);
      tbl[6]  = v(0, 0, 0, 0,     0, 0, 0,     1, 5,  5, 0, 'h00, 'h00,  0, 0, 0);
      tbl[7]  = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  5, 0, 'h00, 'h00,  1, 0, 1);
      tbl[8]  = v(0, 0, 0, 0,     1, 5, 'h7E,  0, 0,  5, 0, 'h7E, 'h00,  0, 0, 0);
      tbl[9]  = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  5, 0, 'h7E, 'h00,  0, 0, 0);
      tbl[10] = v(0, 1, 5, 'h01,  0, 0, 0,     1, 5,  6, 0, 'h00, 'h00,  0, 0, 0);
      tbl[11] = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  5, 5, 'h01, 'h01,  1, 1, 1);
      tbl[12] = v(0, 0, 0, 0,     0, 0, 0,     1, 5,  0, 0, 'h00, 'h00,  0, 0, 1);
      tbl[13] = v(0, 0, 0, 0,     1, 5, 'h55,  0, 0,  1, 1, 'h00, 'h00,  0, 0, 0);
      tbl[14] = v(0, 1, 6, 'h66,  0, 0, 0,     1, 6,  6, 3, 'h66, 'hA5,  0, 0, 0);
      tbl[15] = v(1, 0, 0, 0,     1, 6, 'h99,  0, 0,  6, 3, 'h99, 'hA5,  0, 0, 0);
      tbl[16] = v(0, 0, 0, 0,     0, 0, 0,     0, 0,  6, 3, 'h00, 'h00,  0, 0, 0);

      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Post-reset sweep of every address on both read ports.
      for (int r = 0; r < 32; r++) begin
         raddr_a = 5'(r);
         raddr_b = 5'(31 - r);
         #1;
         check("reset_rdata_a", 32'(rda0), 32'h0);
         check("reset_rdata_b16", 32'(rdb2), 32'h0);
         check("reset_busy_a", 32'(ba), 32'h0);
         check("reset_hazard", 32'(hz), 32'h0);
         check_all();
         tick();
      end

      for (int k = 0; k < 17; k++) begin
         reset = tbl[k].rst; we0 = tbl[k].w0; waddr0 = tbl[k].a0; wdata0 = tbl[k].d0;
         we1 = tbl[k].w1; waddr1 = tbl[k].a1; wdata1 = tbl[k].d1;
         rsv_en = tbl[k].rsv; rsv_addr = tbl[k].rs; raddr_a = tbl[k].ra; raddr_b = tbl[k].rb;
         #1;
         check($sformatf("tbl%0d_rdata_a", k), 32'(rda0), 32'(tbl[k].ex_ra));
         check($sformatf("tbl%0d_rdata_b", k), 32'(rdb0), 32'(tbl[k].ex_rb));
         check($sformatf("tbl%0d_busy_a", k), 32'(ba[0]), 32'(tbl[k].ex_ba));
         check($sformatf("tbl%0d_busy_b", k), 32'(bb[0]), 32'(tbl[k].ex_bb));
         check($sformatf("tbl%0d_hazard", k), 32'(hz[0]), 32'(tbl[k].ex_hz));
         if (k == 4) check("nobypass_rdata_b", 32'(rdb1), 32'h0);
         check_all();
         tick();
      end

      // Address 7: legal for the 8-register instances, out of range for NREGS=6.
      idle();
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 16'hBEEF;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 16'h1234;
      rsv_en = 1'b1; rsv_addr = 5'd7; raddr_a = 5'd7; raddr_b = 5'd7;
      #1;
      check("oor_rdata_a16", 32'(rda2), 32'h0);
      check("oor_busy_a16", 32'(ba[2]), 32'h0);
      check("oor_hazard16", 32'(hz[2]), 32'h0);
      check("r7_bypass_p1", 32'(rda0), 32'h34);
      check("r7_nobypass", 32'(rda1), 32'h0);
      check_all();
      tick();
      idle();
      raddr_a = 5'd7;
      #1;
      check("oor_read16", 32'(rda2), 32'h0);
      check("oor_busy16", 32'(ba[2]), 32'h0);
      check("r7_value", 32'(rda0), 32'h34);
      check("r7_busy", 32'(ba[0]), 32'h1);
      check("r7_hazard", 32'(hz[0]), 32'h1);
      check("r7_nobypass_value", 32'(rda1), 32'h34);
      check_all();
      tick();
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 16'hBEEF; raddr_a = 5'd5;
      #1;
      check("wide_bypass", 32'(rda2), 32'hBEEF);
      check_all();
      tick();
      idle();
      raddr_a = 5'd5;
      #1;
      check("wide_value", 32'(rda2), 32'hBEEF);
      check_all();
      tick();

      for (int c = 0; c < 400; c++) begin
         reset    = ($urandom_range(0, 39) == 0);
         we0      = 1'($urandom_range(0, 1));
         we1      = 1'($urandom_range(0, 1));
         rsv_en   = ($urandom_range(0, 2) == 0);
         waddr0   = rnd_addr();
         waddr1   = rnd_addr();
         raddr_a  = rnd_addr();
         raddr_b  = rnd_addr();
         rsv_addr = rnd_addr();
         wdata0   = 16'($urandom);
         wdata1   = 16'($urandom);
         #1;
         check_all();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
